// File: rtl/ram_pkg.sv
// Shared types and helpers for the banked simple-dual-port RAM.
package ram_pkg;

    typedef enum logic {
        RAM_IDLE  = 1'b0,
        RAM_CLEAR = 1'b1
    } ram_state_t;

    // Width helper that never returns 0, so single-entry/single-bank builds still get a 1-bit field.
    function automatic int safe_clog2(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ram_bank.sv
// One DEPTH x WIDTH bank: a write port and a registered read port.
// The read register samples the old contents on a same-address write (read-first).
module ram_bank
    import ram_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int WIDTH  = 64,
    parameter int ADDR_W = safe_clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is deliberately not reset; contents are zeroed by the clear sequencer.
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (en && re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ram_banked_sdp.sv
// Banked simple-dual-port RAM with LATENCY-cycle tracked reads, global enable and zero-fill sequencer.
// Define RAM_FWD_EN for write-first same-address behaviour; default build is read-first.
module ram_banked_sdp
    import ram_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int WIDTH   = 64,
    parameter int BANKS   = 4,
    parameter int LATENCY = 2,
    parameter int ADDR_W  = safe_clog2(DEPTH),
    parameter int BANK_W  = safe_clog2(BANKS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    output logic              busy,
    input  logic              wr_en,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en,
    input  logic [BANK_W-1:0] rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid,
    output logic [BANK_W-1:0] rd_tag,
    output logic [WIDTH-1:0]  rd_data
);

    typedef struct packed {
        logic              valid;
        logic [BANK_W-1:0] tag;
        logic [WIDTH-1:0]  data;
    } rd_stage_t;

    ram_state_t        state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic              wr_acc, rd_acc;
    logic [BANKS-1:0]  bank_we, bank_re;
    logic [ADDR_W-1:0] bank_waddr;
    logic [WIDTH-1:0]  bank_wdata;
    logic [WIDTH-1:0]  bank_rdata [BANKS];
    logic              s1_valid_q;
    logic [BANK_W-1:0] s1_tag_q;
    logic [WIDTH-1:0]  s1_mem;
    rd_stage_t         s1, s_out;

    assign busy   = (state_q == RAM_CLEAR);
    assign wr_acc = en && wr_en && !busy && !clr;
    assign rd_acc = en && rd_en && !busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RAM_IDLE;
            cnt_q   <= '0;
        end else if (en) begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            RAM_IDLE: begin
                if (clr) begin
                    state_d = RAM_CLEAR;
                    cnt_d   = '0;
                end
            end
            RAM_CLEAR: begin
                if (clr) begin
                    cnt_d = '0;
                end else if (cnt_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = RAM_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = RAM_IDLE;
        endcase
    end

    // During a clear every bank is written at cnt; out-of-range bank selects match no bank.
    always_comb begin
        bank_we = '0;
        bank_re = '0;
        for (int i = 0; i < BANKS; i++) begin
            bank_we[i] = busy || (wr_acc && (wr_bank == BANK_W'(i)));
            bank_re[i] = rd_acc && (rd_bank == BANK_W'(i));
        end
    end

    assign bank_waddr = busy ? cnt_q : wr_addr;
    assign bank_wdata = busy ? '0 : wr_data;

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        ram_bank #(
            .DEPTH  (DEPTH),
            .WIDTH  (WIDTH),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .clk   (clk),
            .rst   (rst),
            .en    (en),
            .we    (bank_we[b]),
            .waddr (bank_waddr),
            .wdata (bank_wdata),
            .re    (bank_re[b]),
            .raddr (rd_addr),
            .rdata (bank_rdata[b])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_tag_q   <= '0;
        end else if (en) begin
            s1_valid_q <= rd_acc;
            s1_tag_q   <= rd_bank;
        end
    end

    always_comb begin
        s1_mem = '0;
        for (int i = 0; i < BANKS; i++) begin
            if (s1_tag_q == BANK_W'(i)) begin
                s1_mem = bank_rdata[i];
            end
        end
    end

`ifdef RAM_FWD_EN
    logic             fwd_hit, fwd_hit_q;
    logic [WIDTH-1:0] fwd_data_q;

    always_comb begin
        fwd_hit = 1'b0;
        for (int i = 0; i < BANKS; i++) begin
            if ((rd_bank == BANK_W'(i)) && (wr_bank == BANK_W'(i))) begin
                fwd_hit = rd_acc && wr_acc && (rd_addr == wr_addr);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
        end else if (en) begin
            fwd_hit_q  <= fwd_hit;
            fwd_data_q <= wr_data;
        end
    end
`endif

    // Data is forced to zero whenever stage 1 holds no read, which also covers reset.
    always_comb begin
        s1.valid = s1_valid_q;
        s1.tag   = s1_tag_q;
`ifdef RAM_FWD_EN
        s1.data  = fwd_hit_q ? fwd_data_q : s1_mem;
`else
        s1.data  = s1_mem;
`endif
        if (!s1_valid_q) begin
            s1.data = '0;
        end
    end

    if (LATENCY > 1) begin : g_pipe
        rd_stage_t pipe_q [LATENCY-1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < LATENCY - 1; i++) begin
                    pipe_q[i] <= '0;
                end
            end else if (en) begin
                pipe_q[0] <= s1;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    pipe_q[i] <= pipe_q[i-1];
                end
            end
        end

        assign s_out = pipe_q[LATENCY-2];
    end else begin : g_nopipe
        assign s_out = s1;
    end

    assign rd_valid = s_out.valid;
    assign rd_tag   = s_out.tag;
    assign rd_data  = s_out.data;

endmodule
